// File: rtl/sblk_row_feeder.sv
// Superblock row feeder: buffers host activation words in a FIFO and streams
// them to the row on request, and hands host instructions to the row while
// tracking the row's busy/idle handshake.
module sblk_row_feeder #(
  parameter int WID_ACT        = 16,
  parameter int WID_INST       = 14,
  parameter int ACT_FIFO_DEPTH = 16,
  parameter int BUSY_WAIT_MAX  = 15
) (
  input  logic                              clk_l,
  input  logic                              rst,
  input  logic [2*WID_ACT-1:0]              host_act_data,
  input  logic                              host_act_vld,
  output logic                              host_act_rdy,
  output logic [2*WID_ACT-1:0]              act_data_in,
  output logic                              act_data_in_vld,
  input  logic                              act_data_in_req,
  input  logic [WID_INST-1:0]               host_inst_data,
  input  logic                              host_inst_vld,
  output logic                              host_inst_rdy,
  output logic [WID_INST-1:0]               inst_data,
  output logic                              inst_en,
  input  logic                              status_sblk,
  output logic                              inst_done,
  output logic                              inst_timeout,
  output logic [$clog2(ACT_FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(ACT_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(ACT_FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_WAIT_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  // Activation FIFO storage and pointers
  logic [2*WID_ACT-1:0] mem [ACT_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic                 pop;

  // Full/empty decisions use only the registered level, so a word written
  // this cycle cannot be popped until the next one (no bypass path).
  assign host_act_rdy = (level != FULL_LVL);
  assign push         = host_act_vld && host_act_rdy;
  assign pop          = act_data_in_req && (level != '0);
  assign fifo_level   = level;

  // FIFO array write; storage is data only and needs no reset
  always_ff @(posedge clk_l) begin
    if (push) mem[wr_ptr] <= host_act_data;
  end

  // FIFO pointers, occupancy and the registered output word
  always_ff @(posedge clk_l) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      act_data_in_vld <= 1'b0;
      act_data_in     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // stage p1: popped word appears one cycle after the request
      act_data_in_vld <= pop;
      if (pop) act_data_in <= mem[rd_ptr];
    end
  end

  // Instruction handshake state
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          inst_en_nxt;
  logic          inst_done_nxt;
  logic          timeout_set;
  logic          capture;

  assign host_inst_rdy = (state == IDLE);

  // Next-state logic; strobes are computed here and registered below
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    inst_en_nxt   = 1'b0;
    inst_done_nxt = 1'b0;
    timeout_set   = 1'b0;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        if (host_inst_vld) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Hold the instruction until the row reports idle
        if (!status_sblk) begin
          inst_en_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        cnt_nxt = cnt + CW'(1);
        if (status_sblk) begin
          state_nxt = WAIT_DONE;
        end else if (cnt_nxt == CNT_MAX) begin
          // Row never acknowledged; retire anyway and flag it
          state_nxt     = IDLE;
          inst_done_nxt = 1'b1;
          timeout_set   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!status_sblk) begin
          state_nxt     = IDLE;
          inst_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, wait counter and registered instruction outputs
  always_ff @(posedge clk_l) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      inst_en      <= 1'b0;
      inst_done    <= 1'b0;
      inst_timeout <= 1'b0;
      inst_data    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      inst_en      <= inst_en_nxt;
      inst_done    <= inst_done_nxt;
      inst_timeout <= inst_timeout | timeout_set;
      if (capture) inst_data <= host_inst_data;
    end
  end

endmodule

// File: tb/tb_sblk_row_feeder.sv
// Bench for sblk_row_feeder: table-driven FIFO vectors, a scoreboard queue for
// activation words, and hand sequences for the instruction handshake and reset.
module tb_sblk_row_feeder;

  localparam int WID_ACT = 16;
  localparam int WID_INST = 14;
  localparam int DEPTH = 16;
  localparam int BUSY_MAX = 15;
  localparam int DW = 2 * WID_ACT;
  localparam int LW = $clog2(DEPTH) + 1;

  logic                clk_l;
  logic                rst;
  logic [DW-1:0]       host_act_data;
  logic                host_act_vld;
  logic                host_act_rdy;
  logic [DW-1:0]       act_data_in;
  logic                act_data_in_vld;
  logic                act_data_in_req;
  logic [WID_INST-1:0] host_inst_data;
  logic                host_inst_vld;
  logic                host_inst_rdy;
  logic [WID_INST-1:0] inst_data;
  logic                inst_en;
  logic                status_sblk;
  logic                inst_done;
  logic                inst_timeout;
  logic [LW-1:0]       fifo_level;

  sblk_row_feeder #(
    .WID_ACT(WID_ACT), .WID_INST(WID_INST),
    .ACT_FIFO_DEPTH(DEPTH), .BUSY_WAIT_MAX(BUSY_MAX)
  ) dut (
    .clk_l(clk_l), .rst(rst),
    .host_act_data(host_act_data), .host_act_vld(host_act_vld), .host_act_rdy(host_act_rdy),
    .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req),
    .host_inst_data(host_inst_data), .host_inst_vld(host_inst_vld), .host_inst_rdy(host_inst_rdy),
    .inst_data(inst_data), .inst_en(inst_en), .status_sblk(status_sblk),
    .inst_done(inst_done), .inst_timeout(inst_timeout), .fifo_level(fifo_level)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic          vld;
    logic [DW-1:0] d;
    logic          req;
    logic [LW-1:0] exp_lvl;
    logic          exp_rdy;
    logic          exp_ovld;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: record accepted pushes, then check any word the DUT emits
  task automatic step();
    if (host_act_vld && host_act_rdy && !rst) sb.push_back(host_act_data);
    @(posedge clk_l);
    #1;
    if (act_data_in_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_vld", 32'(act_data_in), 32'hDEAD_BEEF);
      end else begin
        chk("act_word", 32'(act_data_in), 32'(sb.pop_front()));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1'b1, 32'h0000_00A1, 1'b0, 5'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_00A2, 1'b1, 5'd1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_00A3, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 5'd0, 1'b1, 1'b0};

    rst = 1'b1; host_act_data = '0; host_act_vld = 1'b0; act_data_in_req = 1'b0;
    host_inst_data = '0; host_inst_vld = 1'b0; status_sblk = 1'b0;
    step(); step();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_vld", 32'(act_data_in_vld), 0);
    chk("rst_inst_en", 32'(inst_en), 0);
    chk("rst_timeout", 32'(inst_timeout), 0);
    rst = 1'b0;
    step();
    chk("rel_act_rdy", 32'(host_act_rdy), 1);
    chk("rel_inst_rdy", 32'(host_inst_rdy), 1);

    // Table: push/pop interleave including push+req into an empty FIFO
    for (int i = 0; i < 7; i++) begin
      host_act_vld = tbl[i].vld; host_act_data = tbl[i].d; act_data_in_req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].exp_lvl));
      chk($sformatf("tbl%0d_rdy", i), 32'(host_act_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_vld", i), 32'(act_data_in_vld), 32'(tbl[i].exp_ovld));
    end

    // Fill to full, overflow attempt, then drain back-to-back
    for (int i = 1; i <= 16; i++) begin
      host_act_vld = 1'b1; host_act_data = DW'(i);
      step();
    end
    chk("full_level", 32'(fifo_level), 16);
    chk("full_rdy", 32'(host_act_rdy), 0);
    host_act_data = DW'(32'h11);
    act_data_in_req = 1'b0;
    step();
    host_act_vld = 1'b0;
    chk("overflow_level", 32'(fifo_level), 16);
    act_data_in_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain_vld%0d", i), 32'(act_data_in_vld), 1);
    end
    act_data_in_req = 1'b0;
    step();
    chk("drain_end_vld", 32'(act_data_in_vld), 0);
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Steady push+pop at level 4 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      host_act_vld = 1'b1; host_act_data = DW'(32'h100 + i);
      step();
    end
    act_data_in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      host_act_data = DW'(32'h200 + i);
      step();
      chk($sformatf("steady_level%0d", i), 32'(fifo_level), 4);
    end
    host_act_vld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    act_data_in_req = 1'b0;
    step();
    chk("steady_drain_level", 32'(fifo_level), 0);
    chk("steady_sb_empty", sb.size(), 0);

    // Instruction held off while row busy, then normal busy/done cycle
    status_sblk = 1'b1;
    host_inst_vld = 1'b1; host_inst_data = 14'h1ABC;
    step();
    host_inst_vld = 1'b0;
    chk("issue_inst_rdy", 32'(host_inst_rdy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("held_inst_en%0d", i), 32'(inst_en), 0);
    end
    status_sblk = 1'b0;
    step();
    chk("inst_en_pulse", 32'(inst_en), 1);
    chk("inst_data", 32'(inst_data), 32'h1ABC);
    status_sblk = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inst_done) n++;
      if (i == 0) chk("inst_en_single", 32'(inst_en), 0);
    end
    chk("busy_no_done", n, 0);
    status_sblk = 1'b0;
    step();
    chk("done_pulse", 32'(inst_done), 1);
    chk("done_inst_rdy", 32'(host_inst_rdy), 1);
    step();
    chk("done_single", 32'(inst_done), 0);
    chk("no_timeout", 32'(inst_timeout), 0);
    chk("inst_data_hold", 32'(inst_data), 32'h1ABC);

    // Row never goes busy: timeout after the wait budget
    host_inst_vld = 1'b1; host_inst_data = 14'h0155;
    step();
    host_inst_vld = 1'b0;
    step();
    chk("to_inst_en", 32'(inst_en), 1);
    n = 0;
    while (!inst_done && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, BUSY_MAX);
    chk("to_flag", 32'(inst_timeout), 1);
    for (int i = 0; i < 3; i++) step();
    chk("to_sticky", 32'(inst_timeout), 1);
    chk("to_inst_rdy", 32'(host_inst_rdy), 1);

    // Reset during WAIT_DONE with 7 words queued
    for (int i = 0; i < 7; i++) begin
      host_act_vld = 1'b1; host_act_data = DW'(32'h300 + i);
      step();
    end
    host_act_vld = 1'b0;
    host_inst_vld = 1'b1; host_inst_data = 14'h2222;
    step();
    host_inst_vld = 1'b0;
    step();
    status_sblk = 1'b1;
    step();
    chk("pre_rst_level", 32'(fifo_level), 7);
    chk("pre_rst_inst_rdy", 32'(host_inst_rdy), 0);
    rst = 1'b1; status_sblk = 1'b0;
    sb.delete();
    step();
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_data", 32'(act_data_in), 0);
    chk("mid_rst_inst_data", 32'(inst_data), 0);
    chk("mid_rst_timeout", 32'(inst_timeout), 0);
    chk("mid_rst_inst_rdy", 32'(host_inst_rdy), 1);
    chk("mid_rst_done", 32'(inst_done), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (inst_done) n++;
    end
    chk("post_rst_no_done", n, 0);
    chk("post_rst_act_rdy", 32'(host_act_rdy), 1);
    chk("post_rst_vld", 32'(act_data_in_vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
